// File: rtl/kgp_pkg.sv
// Shared definitions for the KGP-RISC ALU: opcodes, flag bit positions,
// shifter modes and the bit-difference helper.
package kgp_pkg;

  localparam logic [3:0] ALU_PASS = 4'b0000;
  localparam logic [3:0] ALU_ADD  = 4'b0001;
  localparam logic [3:0] ALU_COMP = 4'b0010;
  localparam logic [3:0] ALU_AND  = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SHLL = 4'b0101;
  localparam logic [3:0] ALU_SHRL = 4'b0110;
  localparam logic [3:0] ALU_SHRA = 4'b0111;
  localparam logic [3:0] ALU_DIFF = 4'b1000;

  localparam int FLG_CY = 2;
  localparam int FLG_Z  = 1;
  localparam int FLG_S  = 0;

  typedef enum logic [1:0] {
    SH_LEFT   = 2'd0,
    SH_LRIGHT = 2'd1,
    SH_ARIGHT = 2'd2
  } sh_mode_e;

  // Index of the lowest set bit of x, or 32 when x is all zeros.
  function automatic logic [5:0] lsb_set_index(input logic [31:0] x);
    logic [5:0] idx;
    idx = 6'd32;
    for (int i = 31; i >= 0; i--) begin
      if (x[i]) idx = i[5:0];
    end
    return idx;
  endfunction

endpackage

// File: rtl/alu_shifter.sv
// Combinational 32-bit logarithmic barrel shifter. Left shifts reuse the
// right-shift stages by reversing the data on the way in and out.
module alu_shifter
  import kgp_pkg::*;
(
  input  logic [31:0] i_data,
  input  logic [4:0]  i_amt,
  input  sh_mode_e    i_mode,
  output logic [31:0] o_data
);

  logic        w_left;
  logic        w_fill;
  logic [31:0] w_rev_in;
  logic [31:0] w_rev_out;
  logic [31:0] w_stage [0:5];

  assign w_left = (i_mode == SH_LEFT);
  assign w_fill = (i_mode == SH_ARIGHT) ? i_data[31] : 1'b0;

  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_rev_in
      assign w_rev_in[gi] = i_data[31-gi];
    end

    assign w_stage[0] = w_left ? w_rev_in : i_data;

    // Stage gi conditionally shifts right by 2**gi, filling from the top.
    for (gi = 0; gi < 5; gi++) begin : g_stage
      localparam int SH = 1 << gi;
      assign w_stage[gi+1] = i_amt[gi] ? {{SH{w_fill}}, w_stage[gi][31:SH]}
                                       : w_stage[gi];
    end

    for (gi = 0; gi < 32; gi++) begin : g_rev_out
      assign w_rev_out[gi] = w_stage[5][31-gi];
    end
  endgenerate

  assign o_data = w_left ? w_rev_out : w_stage[5];

endmodule

// File: rtl/kgp_alu.sv
// KGP-RISC 32-bit ALU: combinational operation select followed by a single
// register stage for the result and the carry/zero/sign flags.
module kgp_alu
  import kgp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ip1,
  input  logic [31:0] ip2,
  input  logic [3:0]  alu_signal,
  output logic [31:0] out,
  output logic [2:0]  flags
);

  logic [32:0] w_sum;
  logic [31:0] w_sh_out;
  sh_mode_e    w_sh_mode;
  logic [31:0] w_result;
  logic        w_carry;
  logic [2:0]  w_flags;
  logic [31:0] r_out;
  logic [2:0]  r_flags;

  assign w_sum = {1'b0, ip1} + {1'b0, ip2};

  always_comb begin
    case (alu_signal)
      ALU_SHRL: w_sh_mode = SH_LRIGHT;
      ALU_SHRA: w_sh_mode = SH_ARIGHT;
      default:  w_sh_mode = SH_LEFT;
    endcase
  end

  alu_shifter u_shifter (
    .i_data (ip1),
    .i_amt  (ip2[4:0]),
    .i_mode (w_sh_mode),
    .o_data (w_sh_out)
  );

  always_comb begin
    w_result = '0;
    w_carry  = 1'b0;
    case (alu_signal)
      ALU_PASS: w_result = ip1;
      ALU_ADD: begin
        w_result = w_sum[31:0];
        w_carry  = w_sum[32];
      end
      ALU_COMP: w_result = ~ip2 + 32'd1;
      ALU_AND:  w_result = ip1 & ip2;
      ALU_XOR:  w_result = ip1 ^ ip2;
      ALU_SHLL, ALU_SHRL, ALU_SHRA: w_result = w_sh_out;
      ALU_DIFF: w_result = {26'd0, lsb_set_index(ip1 ^ ip2)};
      default:  w_result = '0;
    endcase
  end

  always_comb begin
    w_flags         = '0;
    w_flags[FLG_CY] = w_carry;
    w_flags[FLG_Z]  = (w_result == 32'd0);
    w_flags[FLG_S]  = w_result[31];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out   <= '0;
      r_flags <= '0;
    end else begin
      r_out   <= w_result;
      r_flags <= w_flags;
    end
  end

  assign out   = r_out;
  assign flags = r_flags;

endmodule

// File: tb/tb_kgp_alu.sv
// Scoreboard bench for kgp_alu: the driver queues hand-computed results,
// the monitor checks them one edge after each applied vector.
module tb_kgp_alu;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ip1;
  logic [31:0] ip2;
  logic [3:0]  alu_signal;
  logic [31:0] out;
  logic [2:0]  flags;

  typedef struct {
    string       name;
    logic [31:0] exp_out;
    logic [2:0]  exp_flags;
    logic        chk_flags;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  kgp_alu dut (
    .clk        (clk),
    .rst        (rst),
    .ip1        (ip1),
    .ip2        (ip2),
    .alu_signal (alu_signal),
    .out        (out),
    .flags      (flags)
  );

  task automatic apply(input string name, input logic r, input logic [31:0] a,
                       input logic [31:0] b, input logic [3:0] op,
                       input logic [31:0] eo, input logic [2:0] ef,
                       input logic cf);
    exp_t e;
    @(negedge clk);
    rst = r; ip1 = a; ip2 = b; alu_signal = op;
    e.name = name; e.exp_out = eo; e.exp_flags = ef; e.chk_flags = cf;
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (out === e.exp_out) n_pass++;
        else $display("FAIL %s out: got %h want %h", e.name, out, e.exp_out);
        if (e.chk_flags) begin
          n_checks++;
          if (flags === e.exp_flags) n_pass++;
          else $display("FAIL %s flags: got %b want %b", e.name, flags, e.exp_flags);
        end
        $display("txn %-10s out=%h flags=%b", e.name, out, flags);
      end
    end
  end

  initial begin : driver
    rst = 1'b1; ip1 = '0; ip2 = '0; alu_signal = '0;
    apply("rst0",     1'b1, 32'hFFFFFFFF, 32'h1, 4'b0001, 32'h0, 3'b000, 1'b1);
    apply("rst1",     1'b1, 32'hFFFFFFFF, 32'h1, 4'b0001, 32'h0, 3'b000, 1'b1);
    apply("add",      1'b0, 32'hFFFFFFFF, 32'h1, 4'b0001, 32'h0,        3'b110, 1'b1);
    apply("comp",     1'b0, 32'hFFFFFFFF, 32'h1, 4'b0010, 32'hFFFFFFFF, 3'b001, 1'b1);
    apply("and",      1'b0, 32'hFFFFFFFF, 32'h1, 4'b0011, 32'h1,        3'b000, 1'b1);
    apply("xor",      1'b0, 32'hFFFFFFFF, 32'h1, 4'b0100, 32'hFFFFFFFE, 3'b001, 1'b1);
    apply("shll",     1'b0, 32'hFFFFFFFF, 32'h1, 4'b0101, 32'hFFFFFFFE, 3'b001, 1'b1);
    apply("shrl",     1'b0, 32'hFFFFFFFF, 32'h1, 4'b0110, 32'h7FFFFFFF, 3'b000, 1'b1);
    apply("shra",     1'b0, 32'hFFFFFFFF, 32'h1, 4'b0111, 32'hFFFFFFFF, 3'b001, 1'b1);
    apply("pass",     1'b0, 32'hFFFFFFFF, 32'h1, 4'b0000, 32'hFFFFFFFF, 3'b001, 1'b1);
    apply("diff8",    1'b0, 32'h8,        32'h0, 4'b1000, 32'd3,        3'b000, 1'b1);
    apply("diffeq",   1'b0, 32'h5,        32'h5, 4'b1000, 32'd32,       3'b000, 1'b1);
    apply("diff31",   1'b0, 32'h80000000, 32'h0, 4'b1000, 32'd31,       3'b000, 1'b1);
    apply("addovf",   1'b0, 32'h7FFFFFFF, 32'h1, 4'b0001, 32'h80000000, 3'b001, 1'b1);
    apply("shra21",   1'b0, 32'h80000000, 32'h21, 4'b0111, 32'hC0000000, 3'b001, 1'b1);
    apply("shrl1f",   1'b0, 32'h80000000, 32'h1F, 4'b0110, 32'h1,        3'b000, 1'b1);
    apply("shll0",    1'b0, 32'h12345678, 32'h20, 4'b0101, 32'h12345678, 3'b000, 1'b1);
    apply("shll4",    1'b0, 32'h12345678, 32'h4,  4'b0101, 32'h23456780, 3'b000, 1'b1);
    apply("rsvd",     1'b0, 32'hFFFFFFFF, 32'h1, 4'b1111, 32'h0,        3'b010, 1'b1);
    apply("midrst",   1'b1, 32'h5,        32'h0, 4'b0000, 32'h0,        3'b000, 1'b1);
    apply("postrst",  1'b0, 32'h5,        32'h3, 4'b0011, 32'h1,        3'b000, 1'b1);
    apply("compneg",  1'b0, 32'h0,        32'h80000000, 4'b0010, 32'h80000000, 3'b001, 1'b1);
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending want 0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
